// File: rtl/wb_commit_sequencer.sv
// rtl/wb_commit_sequencer.sv - serialises up to two retiring writebacks per cycle onto a single-entry debug trace port
// In-order FIFO: lane i1 before lane i2, one commit per cycle, stall when full.
module wb_commit_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i1_valid,
  input  logic [31:0] i1_pc,
  input  logic        i1_we,
  input  logic [4:0]  i1_waddr,
  input  logic [31:0] i1_wdata,
  input  logic        i2_valid,
  input  logic [31:0] i2_pc,
  input  logic        i2_we,
  input  logic [4:0]  i2_waddr,
  input  logic [31:0] i2_wdata,
  output logic        stall_req,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] commit_cnt,
  output logic        overflow_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0] pc_mem    [0:DEPTH-1];
  logic        we_mem    [0:DEPTH-1];
  logic [4:0]  waddr_mem [0:DEPTH-1];
  logic [31:0] wdata_mem [0:DEPTH-1];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             push1;
  logic             push2;
  logic             pop;
  logic [1:0]       n_enq;
  logic [PTR_W-1:0] i2_slot;

  assign stall_req = (count == FULL_CNT);
  assign push1     = ~stall_req & i1_valid;
  assign push2     = ~stall_req & i2_valid;
  assign pop       = (count != '0);
  assign n_enq     = {1'b0, push1} + {1'b0, push2};
  // A lone i2 takes wr_ptr itself; behind i1 it takes the next slot.
  assign i2_slot   = wr_ptr + PTR_W'(push1);

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push1) begin
      pc_mem[wr_ptr]    <= i1_pc;
      we_mem[wr_ptr]    <= i1_we;
      waddr_mem[wr_ptr] <= i1_waddr;
      wdata_mem[wr_ptr] <= i1_wdata;
    end
    if (push2) begin
      pc_mem[i2_slot]    <= i2_pc;
      we_mem[i2_slot]    <= i2_we;
      waddr_mem[i2_slot] <= i2_waddr;
      wdata_mem[i2_slot] <= i2_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_enq);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + (PTR_W+1)'(n_enq) - (PTR_W+1)'(pop);
    end
  end

  // Head is read before this edge's writes land, so a pair accepted at
  // DEPTH-1 may safely overwrite the slot being popped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
      commit_cnt        <= '0;
    end else if (pop) begin
      debug_wb_pc       <= pc_mem[rd_ptr];
      debug_wb_rf_wen   <= {4{we_mem[rd_ptr]}};
      debug_wb_rf_wnum  <= waddr_mem[rd_ptr];
      debug_wb_rf_wdata <= wdata_mem[rd_ptr];
      commit_cnt        <= commit_cnt + 32'd1;
    end else begin
      debug_wb_rf_wen   <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_err <= 1'b0;
    end else if (stall_req && (i1_valid || i2_valid)) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_commit_sequencer.sv
// tb/tb_wb_commit_sequencer.sv - self-checking bench for wb_commit_sequencer
// Directed vector table, hand sequences and random traffic against a queue model.
module tb_wb_commit_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i1_valid, i2_valid;
  logic [31:0] i1_pc, i2_pc, i1_wdata, i2_wdata;
  logic        i1_we, i2_we;
  logic [4:0]  i1_waddr, i2_waddr;
  logic        stall_req;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] commit_cnt;
  logic        overflow_err;

  wb_commit_sequencer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .i1_valid(i1_valid), .i1_pc(i1_pc), .i1_we(i1_we), .i1_waddr(i1_waddr), .i1_wdata(i1_wdata),
    .i2_valid(i2_valid), .i2_pc(i2_pc), .i2_we(i2_we), .i2_waddr(i2_waddr), .i2_wdata(i2_wdata),
    .stall_req(stall_req), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .commit_cnt(commit_cnt), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } lane_t;

  typedef struct {
    lane_t       l1;
    lane_t       l2;
    logic [3:0]  e_wen;
    logic [31:0] e_pc;
    logic [4:0]  e_wnum;
    logic [31:0] e_cnt;
    logic        e_stall;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  lane_t       mq[$];
  logic [31:0] m_pc, m_wdata, m_cnt;
  logic [3:0]  m_wen;
  logic [4:0]  m_wnum;
  logic        m_ovf;

  vec_t tbl[20];
  lane_t idle_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic lane_t mkl(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] a);
    lane_t l;
    l.v = v; l.pc = pc; l.we = we; l.waddr = a; l.wdata = pc ^ 32'h5A5A_A5A5;
    return l;
  endfunction

  function automatic vec_t mkv(input lane_t l1, input lane_t l2, input logic [3:0] wen,
                               input logic [31:0] pc, input logic [4:0] wnum,
                               input logic [31:0] cnt, input logic st);
    vec_t r;
    r.l1 = l1; r.l2 = l2; r.e_wen = wen; r.e_pc = pc; r.e_wnum = wnum; r.e_cnt = cnt; r.e_stall = st;
    return r;
  endfunction

  function automatic lane_t rnd_lane(input logic v);
    lane_t l;
    l.v = v; l.pc = $urandom; l.we = 1'($urandom_range(0, 1));
    l.waddr = 5'($urandom_range(0, 31)); l.wdata = $urandom;
    return l;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = '0; m_wen = '0; m_wnum = '0; m_wdata = '0; m_cnt = '0; m_ovf = 1'b0;
  endtask

  // Commit the head first, then accept the new lanes in program order.
  task automatic model_edge(input lane_t l1, input lane_t l2);
    bit full;
    lane_t h;
    full = (mq.size() == DEPTH);
    if (mq.size() != 0) begin
      h = mq.pop_front();
      m_pc = h.pc; m_wen = {4{h.we}}; m_wnum = h.waddr; m_wdata = h.wdata; m_cnt = m_cnt + 1;
    end else begin
      m_wen = '0;
    end
    if (!full) begin
      if (l1.v) mq.push_back(l1);
      if (l2.v) mq.push_back(l2);
    end else if (l1.v || l2.v) begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic drive(input lane_t l1, input lane_t l2);
    i1_valid = l1.v; i1_pc = l1.pc; i1_we = l1.we; i1_waddr = l1.waddr; i1_wdata = l1.wdata;
    i2_valid = l2.v; i2_pc = l2.pc; i2_we = l2.we; i2_waddr = l2.waddr; i2_wdata = l2.wdata;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".pc"},       debug_wb_pc,               m_pc);
    chk({tag, ".wen"},      32'(debug_wb_rf_wen),      32'(m_wen));
    chk({tag, ".wnum"},     32'(debug_wb_rf_wnum),     32'(m_wnum));
    chk({tag, ".wdata"},    debug_wb_rf_wdata,         m_wdata);
    chk({tag, ".cnt"},      commit_cnt,                m_cnt);
    chk({tag, ".stall"},    32'(stall_req),            32'(mq.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow_err),         32'(m_ovf));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".pc"},       debug_wb_pc,           32'h0);
    chk({tag, ".wen"},      32'(debug_wb_rf_wen),  32'h0);
    chk({tag, ".wnum"},     32'(debug_wb_rf_wnum), 32'h0);
    chk({tag, ".wdata"},    debug_wb_rf_wdata,     32'h0);
    chk({tag, ".cnt"},      commit_cnt,            32'h0);
    chk({tag, ".stall"},    32'(stall_req),        32'h0);
    chk({tag, ".overflow"}, 32'(overflow_err),     32'h0);
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input lane_t l1, input lane_t l2, input string tag);
    drive(l1, l2);
    @(posedge clk);
    model_edge(l1, l2);
    @(negedge clk);
    compare_model(tag);
  endtask

  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      drive(rnd_lane(1'($urandom_range(0, 1))), rnd_lane(1'($urandom_range(0, 1))));
      @(negedge clk);
      check_cleared("reset_hold");
    end
    drive(idle_l, idle_l);
    resetn = 1'b1;
  endtask

  initial begin
    idle_l = mkl(1'b0, 32'h0, 1'b0, 5'd0);
    resetn = 1'b0;
    drive(idle_l, idle_l);

    tbl[0]  = mkv(mkl(1, 32'hBFC0_0000, 1, 5'd8), idle_l, 4'h0, 32'h0, 5'd0, 0, 0);
    tbl[0].l1.wdata = 32'h0000_1234;
    tbl[1]  = mkv(idle_l, idle_l, 4'hF, 32'hBFC0_0000, 5'd8, 1, 0);
    tbl[2]  = mkv(idle_l, idle_l, 4'h0, 32'hBFC0_0000, 5'd8, 1, 0);
    tbl[3]  = mkv(mkl(1, 32'hBFC0_0010, 1, 5'd3), mkl(1, 32'hBFC0_0014, 0, 5'd4),
                  4'h0, 32'hBFC0_0000, 5'd8, 1, 0);
    tbl[4]  = mkv(idle_l, idle_l, 4'hF, 32'hBFC0_0010, 5'd3, 2, 0);
    tbl[5]  = mkv(idle_l, idle_l, 4'h0, 32'hBFC0_0014, 5'd4, 3, 0);
    tbl[6]  = mkv(idle_l, idle_l, 4'h0, 32'hBFC0_0014, 5'd4, 3, 0);
    tbl[7]  = mkv(mkl(1, 32'h100, 1, 5'd16), mkl(1, 32'h104, 1, 5'd17), 4'h0, 32'hBFC0_0014, 5'd4, 3, 0);
    tbl[8]  = mkv(mkl(1, 32'h108, 1, 5'd18), mkl(1, 32'h10C, 1, 5'd19), 4'hF, 32'h100, 5'd16, 4, 0);
    tbl[9]  = mkv(mkl(1, 32'h110, 1, 5'd20), mkl(1, 32'h114, 1, 5'd21), 4'hF, 32'h104, 5'd17, 5, 1);
    tbl[10] = mkv(idle_l, idle_l, 4'hF, 32'h108, 5'd18, 6, 0);
    tbl[11] = mkv(idle_l, idle_l, 4'hF, 32'h10C, 5'd19, 7, 0);
    tbl[12] = mkv(idle_l, idle_l, 4'hF, 32'h110, 5'd20, 8, 0);
    tbl[13] = mkv(idle_l, idle_l, 4'hF, 32'h114, 5'd21, 9, 0);
    tbl[14] = mkv(idle_l, idle_l, 4'h0, 32'h114, 5'd21, 9, 0);
    tbl[15] = mkv(idle_l, mkl(1, 32'h200, 1, 5'd9), 4'h0, 32'h114, 5'd21, 9, 0);
    tbl[16] = mkv(idle_l, idle_l, 4'hF, 32'h200, 5'd9, 10, 0);
    tbl[17] = mkv(mkl(1, 32'h204, 1, 5'd10), idle_l, 4'h0, 32'h200, 5'd9, 10, 0);
    tbl[18] = mkv(idle_l, idle_l, 4'hF, 32'h204, 5'd10, 11, 0);
    tbl[19] = mkv(idle_l, idle_l, 4'h0, 32'h204, 5'd10, 11, 0);

    @(negedge clk);
    do_reset(3);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].l1, tbl[i].l2, $sformatf("vec%0d_model", i));
      chk($sformatf("vec%0d.wen", i),   32'(debug_wb_rf_wen),  32'(tbl[i].e_wen));
      chk($sformatf("vec%0d.pc", i),    debug_wb_pc,           tbl[i].e_pc);
      chk($sformatf("vec%0d.wnum", i),  32'(debug_wb_rf_wnum), 32'(tbl[i].e_wnum));
      chk($sformatf("vec%0d.cnt", i),   commit_cnt,            tbl[i].e_cnt);
      chk($sformatf("vec%0d.stall", i), 32'(stall_req),        32'(tbl[i].e_stall));
    end
    chk("single_lane.wdata_seen", 32'(m_cnt), 32'd11);

    // Random traffic that honours stall_req.
    for (int i = 0; i < 400; i++) begin
      if (mq.size() == DEPTH)
        step(idle_l, idle_l, "rand");
      else
        step(rnd_lane(1'($urandom_range(0, 3) != 0)), rnd_lane(1'($urandom_range(0, 3) != 0)), "rand");
    end

    // Asynchronous reset in the middle of the low phase, with entries buffered.
    step(rnd_lane(1), rnd_lane(1), "pre_async");
    step(rnd_lane(1), rnd_lane(1), "pre_async");
    #2 resetn = 1'b0;
    #1 check_cleared("async_reset");
    model_reset();
    @(negedge clk);
    do_reset(2);
    for (int i = 0; i < 3; i++) step(idle_l, idle_l, "post_reset_idle");

    // Overflow: fill to stall, push once more, then drain.
    step(mkl(1, 32'h300, 1, 5'd1), mkl(1, 32'h304, 0, 5'd2), "ovf_fill");
    step(mkl(1, 32'h308, 1, 5'd3), mkl(1, 32'h30C, 1, 5'd4), "ovf_fill");
    step(mkl(1, 32'h310, 0, 5'd5), mkl(1, 32'h314, 1, 5'd6), "ovf_fill");
    chk("ovf.stall_before", 32'(stall_req), 32'd1);
    step(mkl(1, 32'hDEAD_0000, 1, 5'd31), idle_l, "ovf_violate");
    chk("ovf.sticky_set", 32'(overflow_err), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(idle_l, idle_l, "ovf_drain");
      chk("ovf.no_dead_pc", 32'(debug_wb_pc == 32'hDEAD_0000), 32'd0);
    end
    chk("ovf.last_pc", debug_wb_pc, 32'h314);
    chk("ovf.still_set", 32'(overflow_err), 32'd1);
    do_reset(1);
    step(idle_l, idle_l, "ovf_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
